// File: rtl/wb_master_arb_if.sv
// wb_master_arb_if: requester (m0..m2) and slave-side Wishbone signals of the round-robin master arbiter.
// Modport master = arbiter view, modport slave = requesters plus bus slave view.
interface wb_master_arb_if;
  logic        m0_cyc, m0_stb, m0_we, m0_cab, m0_ack, m0_err, m0_rty;
  logic        m1_cyc, m1_stb, m1_we, m1_cab, m1_ack, m1_err, m1_rty;
  logic        m2_cyc, m2_stb, m2_we, m2_cab, m2_ack, m2_err, m2_rty;
  logic [3:0]  m0_sel, m1_sel, m2_sel, s_sel;
  logic [31:0] m0_adr, m0_dat_i, m0_dat64_i, m0_dat_o, m0_dat64_o;
  logic [31:0] m1_adr, m1_dat_i, m1_dat64_i, m1_dat_o, m1_dat64_o;
  logic [31:0] m2_adr, m2_dat_i, m2_dat64_i, m2_dat_o, m2_dat64_o;
  logic        s_cyc, s_stb, s_we, s_cab, s_ack, s_err, s_rty;
  logic [31:0] s_adr, s_dat_i, s_dat64_i, s_dat_o, s_dat64_o;
  modport master (
    input  m0_cyc, m0_stb, m0_we, m0_cab, m0_sel, m0_adr, m0_dat_i, m0_dat64_i,
    input  m1_cyc, m1_stb, m1_we, m1_cab, m1_sel, m1_adr, m1_dat_i, m1_dat64_i,
    input  m2_cyc, m2_stb, m2_we, m2_cab, m2_sel, m2_adr, m2_dat_i, m2_dat64_i,
    output m0_dat_o, m0_dat64_o, m0_ack, m0_err, m0_rty,
    output m1_dat_o, m1_dat64_o, m1_ack, m1_err, m1_rty,
    output m2_dat_o, m2_dat64_o, m2_ack, m2_err, m2_rty,
    output s_cyc, s_stb, s_we, s_cab, s_sel, s_adr, s_dat_i, s_dat64_i,
    input  s_dat_o, s_dat64_o, s_ack, s_err, s_rty
  );
  modport slave (
    output m0_cyc, m0_stb, m0_we, m0_cab, m0_sel, m0_adr, m0_dat_i, m0_dat64_i,
    output m1_cyc, m1_stb, m1_we, m1_cab, m1_sel, m1_adr, m1_dat_i, m1_dat64_i,
    output m2_cyc, m2_stb, m2_we, m2_cab, m2_sel, m2_adr, m2_dat_i, m2_dat64_i,
    input  m0_dat_o, m0_dat64_o, m0_ack, m0_err, m0_rty,
    input  m1_dat_o, m1_dat64_o, m1_ack, m1_err, m1_rty,
    input  m2_dat_o, m2_dat64_o, m2_ack, m2_err, m2_rty,
    input  s_cyc, s_stb, s_we, s_cab, s_sel, s_adr, s_dat_i, s_dat64_i,
    output s_dat_o, s_dat64_o, s_ack, s_err, s_rty
  );
endinterface

// File: rtl/wb_master_arb.sv
// wb_master_arb: round-robin arbiter for three Wishbone requesters onto one 64-bit master port, with bus watchdog.
// Ports: wb_clk_i/wb_rst_i (async active-high), bus (requester + slave signals), tmo_clear in, tmo_flag/arb_state out.
module wb_master_arb #(
  parameter int TMO_W   = 10,
  parameter int TMO_MAX = 1023
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_master_arb_if.master        bus,
  input  logic                   tmo_clear,
  output logic                   tmo_flag,
  output logic [3:0]             arb_state
);
  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_OWN2} state_t;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);
  state_t           state;
  logic [1:0]       last, c1, c2, win;
  logic [TMO_W-1:0] wdt;
  logic [3:0]       req;
  logic [2:0]       own;
  logic             own_cyc, term, active, tmo;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
  assign req     = {1'b0, bus.m2_cyc, bus.m1_cyc, bus.m0_cyc};
  assign own     = {state == S_OWN2, state == S_OWN1, state == S_OWN0};
  assign own_cyc = |(own & req[2:0]);
  assign c1      = nxt(last);
  assign c2      = nxt(c1);
  assign win     = req[c1] ? c1 : req[c2] ? c2 : last;
  assign bus.s_cyc     = |(own & {bus.m2_cyc, bus.m1_cyc, bus.m0_cyc});
  assign bus.s_stb     = |(own & {bus.m2_stb, bus.m1_stb, bus.m0_stb});
  assign bus.s_we      = |(own & {bus.m2_we,  bus.m1_we,  bus.m0_we});
  assign bus.s_cab     = |(own & {bus.m2_cab, bus.m1_cab, bus.m0_cab});
  assign bus.s_sel     = ({4{own[0]}} & bus.m0_sel) | ({4{own[1]}} & bus.m1_sel) | ({4{own[2]}} & bus.m2_sel);
  assign bus.s_adr     = ({32{own[0]}} & bus.m0_adr) | ({32{own[1]}} & bus.m1_adr) | ({32{own[2]}} & bus.m2_adr);
  assign bus.s_dat_i   = ({32{own[0]}} & bus.m0_dat_i) | ({32{own[1]}} & bus.m1_dat_i) | ({32{own[2]}} & bus.m2_dat_i);
  assign bus.s_dat64_i = ({32{own[0]}} & bus.m0_dat64_i) | ({32{own[1]}} & bus.m1_dat64_i) | ({32{own[2]}} & bus.m2_dat64_i);
  assign term   = bus.s_ack | bus.s_err | bus.s_rty;
  assign active = |own & bus.s_stb;
  // Synthesized error only when the slave stays silent on the terminal count cycle.
  assign tmo    = active & ~term & (wdt == TMO_LIM);
  assign bus.m0_ack = own[0] & bus.s_ack;
  assign bus.m1_ack = own[1] & bus.s_ack;
  assign bus.m2_ack = own[2] & bus.s_ack;
  assign bus.m0_err = own[0] & (bus.s_err | tmo);
  assign bus.m1_err = own[1] & (bus.s_err | tmo);
  assign bus.m2_err = own[2] & (bus.s_err | tmo);
  assign bus.m0_rty = own[0] & bus.s_rty;
  assign bus.m1_rty = own[1] & bus.s_rty;
  assign bus.m2_rty = own[2] & bus.s_rty;
  assign bus.m0_dat_o   = bus.s_dat_o;
  assign bus.m1_dat_o   = bus.s_dat_o;
  assign bus.m2_dat_o   = bus.s_dat_o;
  assign bus.m0_dat64_o = bus.s_dat64_o;
  assign bus.m1_dat64_o = bus.s_dat64_o;
  assign bus.m2_dat64_o = bus.s_dat64_o;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      last      <= 2'd2;
      wdt       <= '0;
      tmo_flag  <= 1'b0;
      arb_state <= 4'd0;
    end else begin
      wdt      <= (!active || term || tmo) ? '0 : wdt + TMO_W'(1);
      tmo_flag <= tmo | (tmo_flag & ~tmo_clear);
      if (state == S_IDLE) begin
        if (|req) begin
          state     <= state_t'(win + 2'd1);
          last      <= win;
          arb_state <= {2'b10, win};
        end
      end else if (!own_cyc) begin
        state     <= S_IDLE;
        arb_state <= 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_wb_master_arb.sv
// tb_wb_master_arb: scoreboard bench for wb_master_arb covering grant order, bursts, write path, watchdog, retry and reset.
module tb_wb_master_arb;
  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  logic tmo_clear = 1'b0;
  logic tmo_flag;
  logic [3:0] arb_state;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  wb_master_arb_if bus();
  wb_master_arb #(.TMO_W(4), .TMO_MAX(15)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .bus(bus),
    .tmo_clear(tmo_clear), .tmo_flag(tmo_flag), .arb_state(arb_state)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_all();
    {bus.m0_cyc, bus.m0_stb, bus.m0_we, bus.m0_cab} = '0;
    {bus.m1_cyc, bus.m1_stb, bus.m1_we, bus.m1_cab} = '0;
    {bus.m2_cyc, bus.m2_stb, bus.m2_we, bus.m2_cab} = '0;
    bus.m0_sel = 4'hf; bus.m1_sel = 4'hf; bus.m2_sel = 4'hf;
    bus.m0_adr = '0; bus.m1_adr = '0; bus.m2_adr = '0;
    bus.m0_dat_i = '0; bus.m1_dat_i = '0; bus.m2_dat_i = '0;
    bus.m0_dat64_i = '0; bus.m1_dat64_i = '0; bus.m2_dat64_i = '0;
    {bus.s_ack, bus.s_err, bus.s_rty} = '0;
    bus.s_dat_o = '0; bus.s_dat64_o = '0;
  endtask
  task automatic test_reset();
    clr_all();
    repeat (2) tick();
    #1;
    checks++; if (bus.s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc); end
    checks++; if (bus.s_adr !== 32'h0) begin errors++; $display("FAIL reset_s_adr: got %h want 0", bus.s_adr); end
    checks++; if (arb_state !== 4'h0) begin errors++; $display("FAIL reset_arb_state: got %h want 0", arb_state); end
    checks++; if (tmo_flag !== 1'b0) begin errors++; $display("FAIL reset_tmo_flag: got %b want 0", tmo_flag); end
    checks++; if ({bus.m0_ack, bus.m1_ack, bus.m2_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b want 000", {bus.m0_ack, bus.m1_ack, bus.m2_ack}); end
    tick();
    wb_rst_i = 1'b0;
  endtask
  task automatic test_arbitration();
    tick();
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_cab = 1; bus.m0_adr = 32'h1000;
    bus.m1_cyc = 1; bus.m1_stb = 1; bus.m1_adr = 32'h2000;
    #1;
    checks++; if (bus.s_cyc !== 1'b0) begin errors++; $display("FAIL grant_latency: got s_cyc %b want 0", bus.s_cyc); end
    tick(); #1;
    checks++; if (arb_state !== 4'h8) begin errors++; $display("FAIL grant_m0_state: got %h want 8", arb_state); end
    checks++; if (bus.s_adr !== 32'h1000) begin errors++; $display("FAIL grant_m0_adr: got %h want 00001000", bus.s_adr); end
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      bus.m0_adr = 32'h1000 + 32'(8 * b);
      bus.s_ack = 1; bus.s_dat_o = 32'hD000_0000 + 32'(b); bus.s_dat64_o = 32'hE000_0000 + 32'(b);
      exp_q.push_back({bus.s_dat64_o, bus.s_dat_o});
      #1;
      checks++; if (bus.s_cab !== 1'b1 || bus.s_adr !== 32'h1000 + 32'(8 * b)) begin errors++; $display("FAIL burst_pass beat %0d: got cab %b adr %h want cab 1 adr %h", b, bus.s_cab, bus.s_adr, 32'h1000 + 32'(8 * b)); end
      checks++; if ({bus.m1_ack, bus.m2_ack} !== 2'b00) begin errors++; $display("FAIL burst_nonowner_ack beat %0d: got %b want 00", b, {bus.m1_ack, bus.m2_ack}); end
      if (bus.m0_ack && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if ({bus.m0_dat64_o, bus.m0_dat_o} !== exp_v) begin errors++; $display("FAIL burst_rdata beat %0d: got %h want %h", b, {bus.m0_dat64_o, bus.m0_dat_o}, exp_v); end
      end else begin
        checks++; errors++; $display("FAIL burst_ack beat %0d: got m0_ack %b want 1", b, bus.m0_ack);
      end
    end
    tick();
    bus.s_ack = 0; bus.m0_cyc = 0; bus.m0_stb = 0; bus.m0_cab = 0;
    bus.m2_cyc = 1; bus.m2_stb = 1; bus.m2_we = 1; bus.m2_adr = 32'h3000;
    bus.m2_dat_i = 32'hA5A5_0001; bus.m2_dat64_i = 32'h5A5A_0002;
    exp_q.push_back({32'h5A5A_0002, 32'hA5A5_0001});
    #1;
    checks++; if ({bus.s_cyc, bus.s_stb} !== 2'b00) begin errors++; $display("FAIL release_comb: got %b want 00", {bus.s_cyc, bus.s_stb}); end
    tick(); #1;
    checks++; if (arb_state !== 4'h0 || bus.s_cyc !== 1'b0) begin errors++; $display("FAIL turnaround_idle: got state %h cyc %b want 0 0", arb_state, bus.s_cyc); end
    tick(); #1;
    checks++; if (arb_state !== 4'h9 || bus.s_adr !== 32'h2000) begin errors++; $display("FAIL grant_m1: got state %h adr %h want 9 00002000", arb_state, bus.s_adr); end
    bus.s_ack = 1; #1;
    checks++; if ({bus.m2_ack, bus.m1_ack, bus.m0_ack} !== 3'b010) begin errors++; $display("FAIL m1_ack_route: got %b want 010", {bus.m2_ack, bus.m1_ack, bus.m0_ack}); end
    tick();
    bus.s_ack = 0; bus.m1_cyc = 0; bus.m1_stb = 0;
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_adr = 32'h1040;
    tick(); tick(); #1;
    checks++; if (arb_state !== 4'hA || bus.s_adr !== 32'h3000 || bus.s_we !== 1'b1) begin errors++; $display("FAIL grant_m2: got state %h adr %h we %b want A 00003000 1", arb_state, bus.s_adr, bus.s_we); end
    bus.s_ack = 1; #1;
    if (bus.s_stb && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++; if ({bus.s_dat64_i, bus.s_dat_i} !== exp_v) begin errors++; $display("FAIL m2_wdata: got %h want %h", {bus.s_dat64_i, bus.s_dat_i}, exp_v); end
    end else begin
      checks++; errors++; $display("FAIL m2_write_stb: got s_stb %b want 1", bus.s_stb);
    end
    checks++; if ({bus.m2_ack, bus.m1_ack, bus.m0_ack} !== 3'b100) begin errors++; $display("FAIL m2_ack_route: got %b want 100", {bus.m2_ack, bus.m1_ack, bus.m0_ack}); end
    tick();
    bus.s_ack = 0; bus.m2_cyc = 0; bus.m2_stb = 0; bus.m2_we = 0;
    tick(); tick(); #1;
    checks++; if (arb_state !== 4'h8 || bus.s_adr !== 32'h1040) begin errors++; $display("FAIL regrant_m0: got state %h adr %h want 8 00001040", arb_state, bus.s_adr); end
    tick();
    bus.m0_cyc = 0; bus.m0_stb = 0;
    tick();
  endtask
  task automatic test_watchdog();
    int first, n;
    tick();
    bus.m1_cyc = 1; bus.m1_stb = 1; bus.m1_adr = 32'h2100;
    #1;
    first = -1;
    for (int c = 0; c < 40 && first < 0; c++) begin tick(); #1; if (bus.m1_err) first = c; end
    checks++; if (first !== 15) begin errors++; $display("FAIL wdt_err_delay: got %0d want 15", first); end
    tick(); #1;
    checks++; if (bus.m1_err !== 1'b0) begin errors++; $display("FAIL wdt_err_pulse: got %b want 0", bus.m1_err); end
    checks++; if (tmo_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag_set: got %b want 1", tmo_flag); end
    tmo_clear = 1;
    tick(); #1; n = 1;
    checks++; if (tmo_flag !== 1'b0) begin errors++; $display("FAIL tmo_flag_clear: got %b want 0", tmo_flag); end
    first = -1;
    while (first < 0 && n < 40) begin tick(); #1; n++; if (bus.m1_err) first = n; end
    checks++; if (first !== 15) begin errors++; $display("FAIL wdt_rearm_delay: got %0d want 15", first); end
    tick(); #1;
    checks++; if (tmo_flag !== 1'b1) begin errors++; $display("FAIL tmo_set_beats_clear: got %b want 1", tmo_flag); end
    tick(); #1;
    checks++; if (tmo_flag !== 1'b0) begin errors++; $display("FAIL tmo_flag_clear2: got %b want 0", tmo_flag); end
    tmo_clear = 0; bus.m1_cyc = 0; bus.m1_stb = 0;
    tick();
  endtask
  task automatic test_retry();
    int first, n;
    tick();
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_adr = 32'h1100;
    tick(); #1;
    checks++; if (arb_state !== 4'h8) begin errors++; $display("FAIL retry_grant: got %h want 8", arb_state); end
    repeat (5) tick();
    bus.s_rty = 1; #1;
    checks++; if ({bus.m0_rty, bus.m1_rty, bus.m0_err} !== 3'b100) begin errors++; $display("FAIL rty_route: got %b want 100", {bus.m0_rty, bus.m1_rty, bus.m0_err}); end
    tick();
    bus.s_rty = 0; #1; n = 0;
    checks++; if (bus.m0_rty !== 1'b0 || arb_state !== 4'h8) begin errors++; $display("FAIL rty_one_cycle: got rty %b state %h want 0 8", bus.m0_rty, arb_state); end
    first = -1;
    while (first < 0 && n < 40) begin tick(); #1; n++; if (bus.m0_err) first = n; end
    checks++; if (first !== 15) begin errors++; $display("FAIL rty_wdt_restart: got %0d want 15", first); end
    tick();
    bus.m0_cyc = 0; bus.m0_stb = 0; tmo_clear = 1;
    tick();
    tmo_clear = 0; #1;
    checks++; if (tmo_flag !== 1'b0) begin errors++; $display("FAIL retry_tmo_clear: got %b want 0", tmo_flag); end
  endtask
  task automatic test_reset_midburst();
    tick();
    bus.m1_cyc = 1; bus.m1_stb = 1; bus.m1_cab = 1; bus.m1_adr = 32'h2200;
    tick();
    bus.s_ack = 1; #1;
    checks++; if ({bus.s_cyc, bus.m1_ack} !== 2'b11) begin errors++; $display("FAIL midburst_active: got %b want 11", {bus.s_cyc, bus.m1_ack}); end
    #1;
    wb_rst_i = 1; #1;
    checks++; if ({bus.s_cyc, bus.s_stb, bus.m1_ack} !== 3'b000) begin errors++; $display("FAIL async_reset_drop: got %b want 000", {bus.s_cyc, bus.s_stb, bus.m1_ack}); end
    bus.s_ack = 0;
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_adr = 32'h1300;
    bus.m2_cyc = 1; bus.m2_stb = 1; bus.m2_adr = 32'h3300;
    tick(); tick();
    wb_rst_i = 0;
    tick(); #1;
    checks++; if (arb_state !== 4'h8 || bus.s_adr !== 32'h1300) begin errors++; $display("FAIL post_reset_m0_wins: got state %h adr %h want 8 00001300", arb_state, bus.s_adr); end
    clr_all();
    tick();
  endtask
  initial begin
    test_reset();
    test_arbitration();
    test_watchdog();
    test_retry();
    test_reset_midburst();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_master_arb.md
# wb_master_arb

Round-robin arbiter that shares the single 64-bit Wishbone master port (the port the DMA descriptor controller and channel engines drive toward the system bus) between three requesters: m0 = descriptor controller, m1/m2 = data channel engines. A requester owns the bus for its whole `cyc` tenure, so descriptor fetches, control write-backs and data bursts are never interleaved. A bus watchdog terminates transfers the slave never answers, so the controller FSMs cannot hang.

## Interface
Parameters:
- `TMO_W`, default 10: watchdog counter width.
- `TMO_MAX`, default 1023: stalled `stb` cycles before a synthesized error.

Ports (N = 0..2, one set per requester):
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `mN_cyc`, `mN_stb`, `mN_we`, `mN_cab`  in  1 each  requester bus controls
- `mN_sel`  in  4  byte select
- `mN_adr`  in  32  address
- `mN_dat_i`, `mN_dat64_i`  in  32 each  write data, low/high word
- `mN_dat_o`, `mN_dat64_o`  out  32 each  read data, low/high word
- `mN_ack`, `mN_err`, `mN_rty`  out  1 each  termination to requester N
- `s_cyc`, `s_stb`, `s_we`, `s_cab`  out  1 each  to the bus slave
- `s_sel`  out  4;  `s_adr`  out  32;  `s_dat_i`, `s_dat64_i`  out  32 each
- `s_dat_o`, `s_dat64_o`  in  32 each;  `s_ack`, `s_err`, `s_rty`  in  1 each
- `tmo_flag`  out  1  sticky watchdog-fired status
- `tmo_clear`  in  1  clears `tmo_flag`
- `arb_state`  out  4  debug: {grant valid, 1'b0, owner[1:0]}

## Operation
- FSM states: S_IDLE, S_OWN0, S_OWN1, S_OWN2. Register `last[1:0]` holds the most recent owner.
- S_IDLE: sample `mN_cyc`. Priority order is round-robin starting after `last`: last=0 → 1,2,0; last=1 → 2,0,1; last=2 → 0,1,2. Move to S_OWNk for the winner and set `last`=k. With no request, stay in S_IDLE.
- S_OWNk, output side: `s_cyc`/`s_stb`/`s_we`/`s_cab`/`s_sel`/`s_adr`/`s_dat_i`/`s_dat64_i` are a combinational mux of requester k's inputs.
- S_OWNk, return side: `mk_ack`/`mk_err`/`mk_rty` = slave terminations OR watchdog error. Non-owners see 0 on all terminations.
- `s_dat_o`/`s_dat64_o` are broadcast to every `mN_dat_o`/`mN_dat64_o` unmodified.
- S_OWNk exits to S_IDLE when `mk_cyc`=0. There is no preemption. Requests from other masters wait.
- In S_IDLE, all `s_*` controls are 0, `s_adr`/`s_dat_i`/`s_dat64_i` are 0, and all `mN_ack/err/rty` are 0.
- Watchdog counter `wdt` (TMO_W bits):
  - Clears when not in an S_OWN state, when `s_stb`=0, or on any `s_ack|s_err|s_rty`.
  - Otherwise increments by 1.
  - When `wdt`==TMO_MAX with no slave termination: assert `mk_err` to the owner for exactly that cycle, set `tmo_flag`, and clear `wdt`.
- `tmo_flag` priority: set beats `tmo_clear` when both occur in the same cycle.
- Reset values: state S_IDLE, `last`=2 (so m0 wins first), `wdt`=0, `tmo_flag`=0, all `s_*` outputs 0, all terminations 0.
- Reset mid-burst drops `s_cyc`/`s_stb` immediately (asynchronous). Requesters must restart.

## Timing
- Grant latency: `mN_cyc` rises in cycle t while in S_IDLE. `s_cyc` follows requester N from cycle t+1. Requests arriving in an S_OWN state are seen in the first S_IDLE cycle after release.
- Release: owner drops `mk_cyc` in cycle t, so `s_cyc` drops in cycle t (combinational path). S_IDLE holds for cycle t+1, and the next owner drives the slave from t+2. The bus turnaround is therefore exactly one idle cycle.
- Path `s_ack` → `mk_ack` is combinational, with zero added latency. Burst `cab` sequences pass through cycle-for-cycle.
- Watchdog error timing: with `s_stb`=1 from cycle t and no termination, `mk_err` pulses in cycle t+TMO_MAX. `tmo_flag` rises in cycle t+TMO_MAX+1.
- `arb_state` is registered and matches the FSM state.

## Test plan
- Reset, then m0 and m1 both raise `cyc` in the same cycle → m0 granted one cycle later. `s_adr` = m0_adr. m1 sees no `ack`.
- m0 does a 4-beat `cab` read (slave acks 4 consecutive cycles), then drops `cyc` while m1 and m2 are requesting → one S_IDLE cycle, then m1 granted. After m1 releases, m2 is granted, then m0.
- m2 write with `s_dat_i`/`s_dat64_i` = 32'hA5A5_0001/32'h5A5A_0002 → slave sees these exact values. `m0_ack`/`m1_ack` stay 0 throughout.
- TMO_MAX=15, m1 holds `stb` with no slave response → `m1_err` pulses 15 cycles after `stb` rose, and `tmo_flag`=1 next cycle. `tmo_clear` returns `tmo_flag` to 0.
- `s_rty` on m0's beat → `m0_rty`=1 for that cycle only. `wdt` resets and m0 keeps the grant.
- Assert `wb_rst_i` during m1's burst → `s_cyc`/`s_stb` go to 0 asynchronously. After reset release with all three masters requesting, m0 wins.
